dino_game_ctrl: RTL and testbench
=================================

DINO_GAME_CTRL -- requirements
Module: dino_game_ctrl

Interface
REQ-001 Parameters SHALL be:
- DINO_X, 100, fixed dino column.
- GROUND_Y, 200, dino resting row and cactus row.
- CAC_START_X, 250, cactus spawn/respawn column.
- SCROLL, 2, cactus leftward step per frame.
- JUMP_V, 12, initial upward speed.
- COLLIDE_EN, 1, 0 disables collision detection.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  system clock (50 MHz, same clock as the VGA display block).
- reset_n  in  1  asynchronous active-low reset.
- vga_vs  in  1  VGA vertical sync from the display timing, active low.
- start_btn  in  1  start/restart request, level, synchronous to clk.
- jump_btn  in  1  jump request, level.
- duck_btn  in  1  duck request, level.
- dino_x  out  8  dino sprite column, feeds the display's dino X register.
- dino_y  out  8  dino sprite row.
- s_cac_x  out  8  cactus column.
- s_cac_y  out  8  cactus row.
- pose  out  2  sprite select: 0 IDLE, 1 RUN, 2 JUMP, 3 DUCK; DEAD reports 1 with game_over high.
- game_over  out  1  high while in DEAD.
- score  out  16  cactus pass count.

Function
REQ-003 Frame tick SHALL be asserted on the clk edge at which vga_vs samples 0 and its previous registered sample was 1. There is exactly one tick per frame.
REQ-004 All state and outputs SHALL change only on tick edges. Buttons SHALL be sampled only at tick edges.
REQ-005 States SHALL be IDLE, RUN, JUMP, DUCK and DEAD.
REQ-006 IDLE: dino_y=GROUND_Y and s_cac_x=CAC_START_X are held. start_btn at a tick SHALL move to RUN.
REQ-007 RUN, at each tick:
- jump_btn SHALL move to JUMP; jump has priority if jump_btn and duck_btn are both high.
- otherwise duck_btn SHALL move to DUCK.
- otherwise the state stays RUN.
REQ-008 JUMP entry SHALL set dino_y=GROUND_Y-JUMP_V and the signed 8-bit velocity v=-JUMP_V+1.
REQ-009 Each later JUMP tick with dino_y+v<GROUND_Y SHALL set dino_y+=v and v+=1.
REQ-010 If dino_y+v>=GROUND_Y, the tick SHALL set dino_y=GROUND_Y and move to RUN (landing). The sum is computed at 10-bit signed width; no wrap.
REQ-011 jump_btn and duck_btn SHALL be ignored during JUMP.
REQ-012 DUCK: if duck_btn is low at a tick, the state SHALL return to RUN. jump_btn is ignored during DUCK.
REQ-013 In RUN, JUMP and DUCK, each tick SHALL move the cactus:
- if s_cac_x<SCROLL: s_cac_x=CAC_START_X and score+=1, saturating at 16'hFFFF.
- otherwise s_cac_x-=SCROLL.
REQ-014 s_cac_y SHALL equal GROUND_Y constantly. dino_x SHALL equal DINO_X constantly.
REQ-015 Collision SHALL be evaluated on the post-update positions of the same tick, at 9-bit unsigned width:
- Horizontal: s_cac_x<=dino_x+31 and dino_x<=s_cac_x+31.
- Vertical: dino_top<=s_cac_y+31 and dino_y+31>=s_cac_y.
- dino_top is dino_y+16 in DUCK, otherwise dino_y.
REQ-016 A collision with COLLIDE_EN=1 SHALL move to DEAD on that tick with game_over=1. A collision SHALL take priority over the landing transition.
REQ-017 DEAD SHALL freeze all positions and score.
REQ-018 start_btn at a tick in DEAD SHALL go to RUN with dino_y=GROUND_Y, s_cac_x=CAC_START_X, score=0 and game_over=0.
REQ-019 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-020 reset_n low SHALL immediately, without a clock, force:
- state IDLE, pose 0.
- dino_x=DINO_X, dino_y=GROUND_Y.
- s_cac_x=CAC_START_X, s_cac_y=GROUND_Y.
- v=0, score=0, game_over=0.
- vs sample register=1.
REQ-021 Reset asserted mid-jump or in DEAD SHALL yield the same values as REQ-020. The first tick SHALL be detected only after a vga_vs 1->0 edge following reset release.

Verification
REQ-022 Release reset, run 3 frames with no buttons -> pose 0, dino_y=200, s_cac_x=250, score 0, game_over 0.
REQ-023 start_btn at tick 1, then 1 more tick -> pose 1, s_cac_x=248. Both jump_btn and duck_btn at the next tick -> pose 2, dino_y=188.
REQ-024 Jump from RUN -> dino_y sequence 188,177,167,... with minimum 122 at jump ticks 12 and 13; lands dino_y=200, pose 1 on jump tick 25.
REQ-025 RUN with no jumps -> DEAD when s_cac_x reaches 130, 60 ticks after start, with game_over=1. 5 further ticks change nothing. start_btn -> s_cac_x=250, score 0, pose 1.
REQ-026 COLLIDE_EN=0 -> s_cac_x reaches 0 after 125 running ticks; the next tick gives s_cac_x=250, score=1.
REQ-027 reset_n pulsed low mid-jump, between clk edges -> all outputs equal the REQ-022 values before the next clk edge.

Source files
------------

// File: rtl/dino_game_ctrl_if.sv
// rtl/dino_game_ctrl_if.sv - button/sync inputs and sprite outputs of the dino game controller
interface dino_game_ctrl_if;
    logic        vga_vs;
    logic        start_btn;
    logic        jump_btn;
    logic        duck_btn;
    logic [7:0]  dino_x;
    logic [7:0]  dino_y;
    logic [7:0]  s_cac_x;
    logic [7:0]  s_cac_y;
    logic [1:0]  pose;
    logic        game_over;
    logic [15:0] score;

    modport master (
        output vga_vs, start_btn, jump_btn, duck_btn,
        input  dino_x, dino_y, s_cac_x, s_cac_y, pose, game_over, score
    );

    modport slave (
        input  vga_vs, start_btn, jump_btn, duck_btn,
        output dino_x, dino_y, s_cac_x, s_cac_y, pose, game_over, score
    );
endinterface

// File: rtl/dino_game_ctrl.sv
// rtl/dino_game_ctrl.sv - frame-ticked dino runner game state machine
module dino_game_ctrl #(
    parameter int DINO_X      = 100,
    parameter int GROUND_Y    = 200,
    parameter int CAC_START_X = 250,
    parameter int SCROLL      = 2,
    parameter int JUMP_V      = 12,
    parameter int COLLIDE_EN  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    dino_game_ctrl_if.slave  gif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_JUMP,
        S_DUCK,
        S_DEAD
    } state_t;

    localparam logic [7:0] DINO_X_C    = 8'(DINO_X);
    localparam logic [7:0] GROUND_C    = 8'(GROUND_Y);
    localparam logic [7:0] CAC_START_C = 8'(CAC_START_X);
    localparam logic [7:0] SCROLL_C    = 8'(SCROLL);
    localparam logic [7:0] JUMP_Y_C    = 8'(GROUND_Y - JUMP_V);
    localparam logic [7:0] JUMP_V0_C   = 8'(1 - JUMP_V);
    localparam logic signed [9:0] GROUND_S = 10'(GROUND_Y);

    state_t      state_q, state_d;
    logic        vs_q, vs_d;
    logic [7:0]  dino_x_q, dino_x_d;
    logic [7:0]  dino_y_q, dino_y_d;
    logic [7:0]  cac_x_q, cac_x_d;
    logic [7:0]  cac_y_q, cac_y_d;
    logic [7:0]  v_q, v_d;
    logic [15:0] score_q, score_d;
    logic [1:0]  pose_q, pose_d;
    logic        game_over_q, game_over_d;

    logic              tick;
    logic              moving;
    logic signed [9:0] land_sum;
    logic [8:0]        cx9, dx9, dy9, cy9, top9;
    logic              hit;

    always_comb begin
        state_d     = state_q;
        dino_x_d    = DINO_X_C;
        dino_y_d    = dino_y_q;
        cac_x_d     = cac_x_q;
        cac_y_d     = GROUND_C;
        v_d         = v_q;
        score_d     = score_q;
        vs_d        = gif.vga_vs;
        tick        = vs_q & ~gif.vga_vs;
        moving      = (state_q == S_RUN) || (state_q == S_JUMP) || (state_q == S_DUCK);
        land_sum    = $signed({2'b00, dino_y_q}) + $signed({{2{v_q[7]}}, v_q});

        if (tick) begin
            if (moving) begin
                if (cac_x_q < SCROLL_C) begin
                    cac_x_d = CAC_START_C;
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end
                end else begin
                    cac_x_d = cac_x_q - SCROLL_C;
                end
            end

            case (state_q)
                S_IDLE: begin
                    dino_y_d = GROUND_C;
                    cac_x_d  = CAC_START_C;
                    if (gif.start_btn) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (gif.jump_btn) begin
                        state_d  = S_JUMP;
                        dino_y_d = JUMP_Y_C;
                        v_d      = JUMP_V0_C;
                    end else if (gif.duck_btn) begin
                        state_d = S_DUCK;
                    end
                end
                S_JUMP: begin
                    // Gravity: velocity grows by one per frame until the dino is back on the ground.
                    if (land_sum >= GROUND_S) begin
                        dino_y_d = GROUND_C;
                        v_d      = 8'd0;
                        state_d  = S_RUN;
                    end else begin
                        dino_y_d = land_sum[7:0];
                        v_d      = v_q + 8'd1;
                    end
                end
                S_DUCK: begin
                    if (!gif.duck_btn) begin
                        state_d = S_RUN;
                    end
                end
                S_DEAD: begin
                    if (gif.start_btn) begin
                        state_d  = S_RUN;
                        dino_y_d = GROUND_C;
                        cac_x_d  = CAC_START_C;
                        score_d  = 16'd0;
                        v_d      = 8'd0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Collision uses this frame's updated positions and overrides landing.
        cx9  = {1'b0, cac_x_d};
        dx9  = {1'b0, DINO_X_C};
        dy9  = {1'b0, dino_y_d};
        cy9  = {1'b0, GROUND_C};
        top9 = (state_d == S_DUCK) ? dy9 + 9'd16 : dy9;
        hit  = (cx9 <= dx9 + 9'd31) && (dx9 <= cx9 + 9'd31) &&
               (top9 <= cy9 + 9'd31) && (dy9 + 9'd31 >= cy9);
        if (tick && moving && hit && (COLLIDE_EN != 0)) begin
            state_d = S_DEAD;
        end

        case (state_d)
            S_IDLE:  pose_d = 2'd0;
            S_JUMP:  pose_d = 2'd2;
            S_DUCK:  pose_d = 2'd3;
            default: pose_d = 2'd1;
        endcase
        game_over_d = (state_d == S_DEAD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            vs_q        <= 1'b1;
            dino_x_q    <= DINO_X_C;
            dino_y_q    <= GROUND_C;
            cac_x_q     <= CAC_START_C;
            cac_y_q     <= GROUND_C;
            v_q         <= 8'd0;
            score_q     <= 16'd0;
            pose_q      <= 2'd0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= vs_d;
            dino_x_q    <= dino_x_d;
            dino_y_q    <= dino_y_d;
            cac_x_q     <= cac_x_d;
            cac_y_q     <= cac_y_d;
            v_q         <= v_d;
            score_q     <= score_d;
            pose_q      <= pose_d;
            game_over_q <= game_over_d;
        end
    end

    assign gif.dino_x    = dino_x_q;
    assign gif.dino_y    = dino_y_q;
    assign gif.s_cac_x   = cac_x_q;
    assign gif.s_cac_y   = cac_y_q;
    assign gif.pose      = pose_q;
    assign gif.game_over = game_over_q;
    assign gif.score     = score_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb/tb_dino_game_ctrl.sv - self-checking bench for dino_game_ctrl against a frame-level game model
module tb_dino_game_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic vs = 1'b1;
    logic st = 1'b0;
    logic jb = 1'b0;
    logic db = 1'b0;

    always #10 clk = ~clk;

    dino_game_ctrl_if ifa();
    dino_game_ctrl_if ifb();

    assign ifa.vga_vs = vs;
    assign ifa.start_btn = st;
    assign ifa.jump_btn = jb;
    assign ifa.duck_btn = db;
    assign ifb.vga_vs = vs;
    assign ifb.start_btn = st;
    assign ifb.jump_btn = jb;
    assign ifb.duck_btn = db;

    dino_game_ctrl #(.COLLIDE_EN(1)) dut_a (.clk(clk), .reset_n(reset_n), .gif(ifa));
    dino_game_ctrl #(.COLLIDE_EN(0)) dut_b (.clk(clk), .reset_n(reset_n), .gif(ifb));

    int checks = 0;
    int failures = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_JUMP = 2, M_DUCK = 3, M_DEAD = 4;
    int m_st, m_y, m_v, m_cx, m_score;

    logic [50:0] rst_vec;

    function automatic void model_reset();
        m_st = M_IDLE; m_y = 200; m_v = 0; m_cx = 250; m_score = 0;
    endfunction

    function automatic void model_tick(bit s, bit j, bit d);
        int prev;
        int top;
        prev = m_st;
        if (prev == M_IDLE) begin
            if (s) m_st = M_RUN;
        end else if (prev == M_DEAD) begin
            if (s) begin
                m_st = M_RUN; m_y = 200; m_cx = 250; m_score = 0; m_v = 0;
            end
        end else begin
            if (m_cx < 2) begin
                m_cx = 250;
                if (m_score < 65535) m_score = m_score + 1;
            end else begin
                m_cx = m_cx - 2;
            end
            if (prev == M_RUN) begin
                if (j) begin m_st = M_JUMP; m_y = 188; m_v = -11; end
                else if (d) m_st = M_DUCK;
            end else if (prev == M_JUMP) begin
                if (m_y + m_v >= 200) begin m_y = 200; m_v = 0; m_st = M_RUN; end
                else begin m_y = m_y + m_v; m_v = m_v + 1; end
            end else if (!d) begin
                m_st = M_RUN;
            end
            top = (m_st == M_DUCK) ? m_y + 16 : m_y;
            if (m_cx <= 131 && 100 <= m_cx + 31 && top <= 231 && m_y + 31 >= 200)
                m_st = M_DEAD;
        end
    endfunction

    function automatic logic [50:0] exp_vec();
        logic [1:0] p;
        case (m_st)
            M_IDLE:  p = 2'd0;
            M_JUMP:  p = 2'd2;
            M_DUCK:  p = 2'd3;
            default: p = 2'd1;
        endcase
        return {p, 8'(m_y), 8'(m_cx), 16'(m_score), (m_st == M_DEAD), 8'd100, 8'd200};
    endfunction

    function automatic logic [50:0] obs_a();
        return {ifa.pose, ifa.dino_y, ifa.s_cac_x, ifa.score, ifa.game_over, ifa.dino_x, ifa.s_cac_y};
    endfunction

    function automatic logic [50:0] obs_b();
        return {ifb.pose, ifb.dino_y, ifb.s_cac_x, ifb.score, ifb.game_over, ifb.dino_x, ifb.s_cac_y};
    endfunction

    task automatic frame(input bit s, input bit j, input bit d);
        @(negedge clk);
        vs = 1'b1; st = s; jb = j; db = d;
        repeat (3) @(negedge clk);
        vs = 1'b0;
        repeat (3) @(negedge clk);
        st = 1'b0; jb = 1'b0; db = 1'b0;
        model_tick(s, j, d);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        vs = 1'b1; st = 1'b0; jb = 1'b0; db = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #3;
        checks++;
        if (obs_a() !== rst_vec) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", obs_a(), rst_vec);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (obs_a() !== rst_vec) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", obs_a(), rst_vec);
        end
    endtask

    task automatic test_idle();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            frame(1'b0, 1'b0, 1'b0);
            checks++;
            if (obs_a() !== rst_vec) begin
                failures++;
                $display("FAIL idle_frame%0d: got %h expected %h", i, obs_a(), rst_vec);
            end
        end
    endtask

    task automatic test_start_jump();
        int ey;
        apply_reset();
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        checks++;
        if (ifa.pose !== 2'd1 || ifa.s_cac_x !== 8'd248) begin
            failures++;
            $display("FAIL start_run: got pose=%0d cac_x=%0d expected pose=1 cac_x=248", ifa.pose, ifa.s_cac_x);
        end
        frame(1'b0, 1'b1, 1'b1);
        checks++;
        if (ifa.pose !== 2'd2 || ifa.dino_y !== 8'd188) begin
            failures++;
            $display("FAIL jump_entry: got pose=%0d y=%0d expected pose=2 y=188", ifa.pose, ifa.dino_y);
        end
        for (int k = 2; k <= 25; k++) begin
            frame(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            ey = 188 - 12 * (k - 1) + ((k - 1) * k) / 2;
            if (k == 25) ey = 200;
            checks++;
            if (ifa.dino_y !== 8'(ey) || ifa.pose !== ((k == 25) ? 2'd1 : 2'd2)) begin
                failures++;
                $display("FAIL jump_tick%0d: got y=%0d pose=%0d expected y=%0d", k, ifa.dino_y, ifa.pose, ey);
            end
            if (k == 12 || k == 13) begin
                checks++;
                if (ifa.dino_y !== 8'd122) begin
                    failures++;
                    $display("FAIL jump_apex%0d: got y=%0d expected 122", k, ifa.dino_y);
                end
            end
        end
        checks++;
        if (obs_a() !== exp_vec()) begin
            failures++;
            $display("FAIL jump_model: got %h expected %h", obs_a(), exp_vec());
        end
    endtask

    task automatic test_collision();
        logic [50:0] dead_vec;
        apply_reset();
        frame(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 59; n++) begin
            frame(1'b0, 1'b0, 1'b0);
            if (ifa.game_over !== 1'b0 || ifa.s_cac_x !== 8'(250 - 2 * n)) begin
                checks++;
                failures++;
                $display("FAIL run_tick%0d: got cac_x=%0d go=%0d expected cac_x=%0d go=0",
                         n, ifa.s_cac_x, ifa.game_over, 250 - 2 * n);
            end
        end
        checks++;
        frame(1'b0, 1'b0, 1'b0);
        dead_vec = {2'd1, 8'd200, 8'd130, 16'd0, 1'b1, 8'd100, 8'd200};
        checks++;
        if (obs_a() !== dead_vec) begin
            failures++;
            $display("FAIL dead_at_130: got %h expected %h", obs_a(), dead_vec);
        end
        for (int i = 0; i < 5; i++) begin
            frame(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        checks++;
        if (obs_a() !== dead_vec) begin
            failures++;
            $display("FAIL dead_frozen: got %h expected %h", obs_a(), dead_vec);
        end
        frame(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_a() !== {2'd1, 8'd200, 8'd250, 16'd0, 1'b0, 8'd100, 8'd200}) begin
            failures++;
            $display("FAIL restart: got %h expected pose=1 y=200 cac_x=250 score=0 go=0", obs_a());
        end
    endtask

    task automatic test_no_collide();
        apply_reset();
        frame(1'b1, 1'b0, 1'b0);
        repeat (125) frame(1'b0, 1'b0, 1'b0);
        checks++;
        if (ifb.s_cac_x !== 8'd0 || ifb.score !== 16'd0 || ifb.game_over !== 1'b0) begin
            failures++;
            $display("FAIL nocol_at_0: got cac_x=%0d score=%0d go=%0d expected 0 0 0",
                     ifb.s_cac_x, ifb.score, ifb.game_over);
        end
        checks++;
        if (ifa.game_over !== 1'b1) begin
            failures++;
            $display("FAIL col_en_dead: got go=%0d expected 1", ifa.game_over);
        end
        frame(1'b0, 1'b0, 1'b0);
        checks++;
        if (ifb.s_cac_x !== 8'd250 || ifb.score !== 16'd1) begin
            failures++;
            $display("FAIL nocol_wrap: got cac_x=%0d score=%0d expected 250 1", ifb.s_cac_x, ifb.score);
        end
    endtask

    task automatic test_random();
        bit s, j, d;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            s = $urandom_range(0, 9) == 0;
            j = $urandom_range(0, 7) == 0;
            d = $urandom_range(0, 3) == 0;
            @(negedge clk);
            st = s; jb = j; db = d;
            repeat (2) @(negedge clk);
            checks++;
            if (obs_a() !== exp_vec()) begin
                failures++;
                $display("FAIL rand_hold%0d: got %h expected %h", i, obs_a(), exp_vec());
            end
            frame(s, j, d);
            checks++;
            if (obs_a() !== exp_vec()) begin
                failures++;
                $display("FAIL rand_frame%0d: got %h expected %h", i, obs_a(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_midjump();
        apply_reset();
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b0);
        repeat (3) frame(1'b0, 1'b0, 1'b0);
        checks++;
        if (ifa.pose !== 2'd2) begin
            failures++;
            $display("FAIL midjump_pre: got pose=%0d expected 2", ifa.pose);
        end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #2;
        checks++;
        if (obs_a() !== rst_vec || obs_b() !== rst_vec) begin
            failures++;
            $display("FAIL midjump_reset: got %h / %h expected %h", obs_a(), obs_b(), rst_vec);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        frame(1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_a() !== rst_vec) begin
            failures++;
            $display("FAIL post_reset_idle: got %h expected %h", obs_a(), rst_vec);
        end
    endtask

    initial begin
        rst_vec = {2'd0, 8'd200, 8'd250, 16'd0, 1'b0, 8'd100, 8'd200};
        model_reset();
        test_reset();
        test_idle();
        test_start_jump();
        test_collision();
        test_no_collide();
        test_random();
        test_reset_midjump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
